tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter: START_TIMEOUT, 16, max cycles in SEND waiting for tx_busy to rise; legal range 2..255.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  4  request per requester; bit i = requester i.
REQ-006 din  in  32  byte for requester i on din[8i+7:8i].
REQ-007 ack  out  4  one-cycle pulse on bit i when requester i's byte is accepted by the transmitter.
REQ-008 tx_send  out  1  send strobe to the UART transmitter.
REQ-009 tx_din  out  8  byte to the UART transmitter.
REQ-010 tx_busy  in  1  busy flag from the UART transmitter.
REQ-011 active  out  1  high whenever the state is not IDLE.
REQ-012 timeout_err  out  1  one-cycle pulse when a start timeout aborts a transaction.
REQ-013 last_grant  out  2  index of the most recently served requester.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND, WAIT_DONE; all outputs registered.
REQ-015 Arbitration SHALL occur only in IDLE, and only on a cycle where tx_busy=0 and req!=0.
REQ-016 Selection SHALL be round-robin: search starts at index last_grant+1 (mod 4) and picks the first set req bit.
REQ-017 On the arbitration edge, the block SHALL latch the winner index and its din byte into tx_din, set tx_send=1, and enter SEND; tx_send is therefore high on the cycle after req is sampled.
REQ-018 tx_din SHALL hold stable from entry into SEND until the return to IDLE.
REQ-019 In SEND, on the edge where tx_busy is sampled 1, the block SHALL set ack[winner]=1 for one cycle, set tx_send=0, update last_grant=winner, and enter WAIT_DONE.
REQ-020 In SEND, if tx_busy has not been sampled 1 within START_TIMEOUT cycles of entering SEND, the next edge SHALL set tx_send=0, pulse timeout_err for one cycle, update last_grant=winner, raise no ack, and enter IDLE.
REQ-021 The timeout counter SHALL clear on every entry into SEND and SHALL saturate rather than wrap.
REQ-022 In WAIT_DONE, the block SHALL enter IDLE on the edge where tx_busy is sampled 0; tx_send SHALL remain 0 throughout.
REQ-023 After returning to IDLE, a new arbitration SHALL be allowed on the very next cycle if req!=0 and tx_busy=0.
REQ-024 A requester dropping req after arbitration SHALL NOT cancel the transaction; the latched byte is sent and ack still pulses.
REQ-025 Requesters SHALL hold req and din stable until ack; the block does not re-sample din after latching.
REQ-026 At most one ack bit SHALL be high in any cycle; ack and timeout_err SHALL never be high in the same cycle.
REQ-027 With req held continuously by all four requesters, service order SHALL be 0,1,2,3,0,... with no starvation.

Reset
REQ-028 While rst=1 at a clock edge, the next state SHALL be IDLE with ack=0, tx_send=0, tx_din=0x00, active=0, timeout_err=0, last_grant=3, and the counter cleared.
REQ-029 Reset SHALL take priority over all transitions, including mid-SEND and mid-WAIT_DONE; an interrupted transaction raises no ack and no timeout_err.

Verification
REQ-030 req=4'b0100, din[23:16]=0x41, and tx_busy rising 2 cycles after tx_send -> tx_send=1 and tx_din=0x41 on the next cycle; ack=4'b0100 for one cycle; last_grant=2; IDLE once tx_busy falls.
REQ-031 req=4'b1111 held, transmitter model with a 10-cycle busy -> ack sequence 0001, 0010, 0100, 1000, 0001.
REQ-032 last_grant=1 and req=4'b1010 -> requester 3 is served first, then requester 1.
REQ-033 START_TIMEOUT=16, req=4'b0001, tx_busy stuck at 0 -> tx_send is high for 16 cycles, then timeout_err pulses once, ack stays 0, last_grant=0, state returns to IDLE.
REQ-034 tx_busy=1 in IDLE with req=4'b0001 -> no tx_send while busy; arbitration occurs on the first cycle tx_busy=0.
REQ-035 rst=1 during WAIT_DONE -> on the next cycle all outputs are at reset values, last_grant=3, and active=0.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// Requester and UART transmitter signals of the tx_arbiter.
// master = environment side, slave = arbiter side.
interface tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic        tx_send;
  logic [7:0]  tx_din;
  logic        tx_busy;
  logic        active;
  logic        timeout_err;
  logic [1:0]  last_grant;

  modport master (
    output req, din, tx_busy,
    input  ack, tx_send, tx_din,
    input  active, timeout_err, last_grant
  );

  modport slave (
    input  req, din, tx_busy,
    output ack, tx_send, tx_din,
    output active, timeout_err, last_grant
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four
// byte requesters, with a start timeout on the busy handshake.
module tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t     r_state;
  logic [3:0] r_ack;
  logic       r_send;
  logic [7:0] r_din;
  logic       r_active;
  logic       r_terr;
  logic [1:0] r_lg;
  logic [1:0] r_win;
  logic [7:0] r_cnt;

  logic [1:0] w_win;
  logic       w_any;

  // first set request at or after last_grant+1, wrapping
  always_comb begin
    logic [1:0] idx;
    idx   = r_lg;
    w_win = r_lg;
    w_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = r_lg + 2'(k);
      if (!w_any && bus.req[idx]) begin
        w_win = idx;
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ack    <= '0;
      r_send   <= 1'b0;
      r_din    <= '0;
      r_active <= 1'b0;
      r_terr   <= 1'b0;
      r_lg     <= 2'd3;
      r_win    <= '0;
      r_cnt    <= '0;
    end else begin
      r_ack  <= '0;
      r_terr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!bus.tx_busy && w_any) begin
            r_win    <= w_win;
            r_din    <= bus.din[{w_win, 3'b000} +: 8];
            r_send   <= 1'b1;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.tx_busy) begin
            r_ack[r_win] <= 1'b1;
            r_send       <= 1'b0;
            r_lg         <= r_win;
            r_state      <= S_WAIT;
          end else if (r_cnt == 8'(START_TIMEOUT - 1)) begin
            r_send   <= 1'b0;
            r_terr   <= 1'b1;
            r_lg     <= r_win;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (!bus.tx_busy) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.tx_send     = r_send;
  assign bus.tx_din      = r_din;
  assign bus.active      = r_active;
  assign bus.timeout_err = r_terr;
  assign bus.last_grant  = r_lg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed scoreboard bench for tx_arbiter with a simple
// UART transmitter busy model.
module tb_tx_arbiter;

  logic clk;
  logic rst;
  tx_arbiter_if bus();

  tx_arbiter #(.NREQ(4), .START_TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] byt;
    logic [1:0] lg;
    logic       terr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic m_busy;
  logic f_busy;
  logic tx_en;
  int   tx_dly;
  int   tx_len;

  assign bus.tx_busy = m_busy | f_busy;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [3:0] a, logic [7:0] b,
                      logic [1:0] lg, logic te);
    exp_t e;
    e.ack = a; e.byt = b; e.lg = lg; e.terr = te;
    q.push_back(e);
  endtask

  // transmitter: busy rises tx_dly cycles after tx_send, lasts tx_len
  initial begin
    int ph;
    int mc;
    m_busy = 1'b0;
    ph = 0;
    mc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ph)
        0: if (tx_en && bus.tx_send) begin
          mc = tx_dly;
          ph = 1;
        end
        1: begin
          mc--;
          if (mc == 0) begin
            m_busy = 1'b1;
            mc = tx_len;
            ph = 2;
          end
        end
        default: begin
          mc--;
          if (mc == 0) begin
            m_busy = 1'b0;
            ph = 0;
          end
        end
      endcase
    end
  end

  // output monitor: pops one expectation per ack or timeout pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.ack != 4'd0 || bus.timeout_err)) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("ack", 32'(bus.ack), 32'(e.ack));
          chk("tx_din", 32'(bus.tx_din), 32'(e.byt));
          chk("last_grant", 32'(bus.last_grant), 32'(e.lg));
          chk("timeout_err", 32'(bus.timeout_err), 32'(e.terr));
        end
      end
    end
  end

  task automatic wait_ack(bit drop);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.ack != 4'd0) begin
        got = 1'b1;
        if (drop) bus.req = bus.req & ~bus.ack;
      end
    end
    chk("ack_wait", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!bus.active && !bus.tx_busy) got = 1'b1;
    end
    chk("idle_wait", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    bus.req = 4'd0;
    bus.din = 32'd0;
    f_busy = 1'b0;
    tx_en = 1'b1;
    tx_dly = 2;
    tx_len = 4;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_send", 32'(bus.tx_send), 32'd0);
    chk("rst_din", 32'(bus.tx_din), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_terr", 32'(bus.timeout_err), 32'd0);
    chk("rst_lg", 32'(bus.last_grant), 32'd3);
    rst = 1'b0;

    // single request from requester 2
    bus.din = 32'h0041_0000;
    bus.req = 4'b0100;
    push(4'b0100, 8'h41, 2'd2, 1'b0);
    @(negedge clk);
    chk("send_rise", 32'(bus.tx_send), 32'd1);
    chk("send_din", 32'(bus.tx_din), 32'h41);
    chk("send_active", 32'(bus.active), 32'd1);
    wait_ack(1'b1);
    @(negedge clk);
    chk("ack_pulse", 32'(bus.ack), 32'd0);
    wait_idle();

    // dropped request still completes with the latched byte
    bus.din = 32'h0000_005A;
    bus.req = 4'b0001;
    push(4'b0001, 8'h5A, 2'd0, 1'b0);
    @(negedge clk);
    chk("drop_send", 32'(bus.tx_send), 32'd1);
    bus.req = 4'd0;
    bus.din = 32'h0000_00FF;
    wait_ack(1'b0);
    wait_idle();

    // reset while in WAIT_DONE
    tx_len = 10;
    bus.din = 32'h0000_7700;
    bus.req = 4'b0010;
    push(4'b0010, 8'h77, 2'd1, 1'b0);
    wait_ack(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wrst_ack", 32'(bus.ack), 32'd0);
    chk("wrst_send", 32'(bus.tx_send), 32'd0);
    chk("wrst_din", 32'(bus.tx_din), 32'd0);
    chk("wrst_active", 32'(bus.active), 32'd0);
    chk("wrst_lg", 32'(bus.last_grant), 32'd3);
    wait_idle();

    // all four requesting: strict rotation from 0
    tx_dly = 1;
    bus.din = 32'hD3C2_B1A0;
    bus.req = 4'b1111;
    push(4'b0001, 8'hA0, 2'd0, 1'b0);
    push(4'b0010, 8'hB1, 2'd1, 1'b0);
    push(4'b0100, 8'hC2, 2'd2, 1'b0);
    push(4'b1000, 8'hD3, 2'd3, 1'b0);
    push(4'b0001, 8'hA0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) wait_ack(1'b0);
    bus.req = 4'd0;
    wait_idle();

    // move last_grant to 1, then 3 wins over 1
    tx_len = 3;
    bus.din = 32'h3300_1100;
    bus.req = 4'b0010;
    push(4'b0010, 8'h11, 2'd1, 1'b0);
    wait_ack(1'b1);
    wait_idle();
    bus.req = 4'b1010;
    push(4'b1000, 8'h33, 2'd3, 1'b0);
    push(4'b0010, 8'h11, 2'd1, 1'b0);
    wait_ack(1'b1);
    wait_ack(1'b1);
    wait_idle();

    // transmitter busy in IDLE blocks arbitration
    f_busy = 1'b1;
    bus.din = 32'h0000_0011;
    bus.req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_hold", 32'(bus.tx_send), 32'd0);
    end
    f_busy = 1'b0;
    push(4'b0001, 8'h11, 2'd0, 1'b0);
    @(negedge clk);
    chk("busy_release", 32'(bus.tx_send), 32'd1);
    wait_ack(1'b1);
    wait_idle();

    // start timeout with a dead transmitter
    tx_en = 1'b0;
    bus.din = 32'h0000_0022;
    bus.req = 4'b0001;
    push(4'b0000, 8'h22, 2'd0, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_send) n++;
      chk("to_noack", 32'(bus.ack), 32'd0);
      if (bus.timeout_err) begin
        seen = 1'b1;
        bus.req = 4'd0;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_send_cycles", 32'(n), 32'd16);
    @(negedge clk);
    chk("to_pulse", 32'(bus.timeout_err), 32'd0);
    chk("to_active", 32'(bus.active), 32'd0);
    chk("to_lg", 32'(bus.last_grant), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_left", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
